// File: rtl/pic_priority_isr_if.sv
// rtl/pic_priority_isr_if.sv - request/acknowledge/EOI bundle between IRR stage, CPU side and the priority/ISR stage
interface pic_priority_isr_if;
   logic [7:0] IRR;
   logic       INTA;
   logic       EOI_CMD;
   logic       SPECIFIC_EOI;
   logic [2:0] EOI_LEVEL;
   logic       ROTATE_ON_EOI;
   logic       AUTO_EOI;
   logic [4:0] VECTOR_BASE;
   logic       INT;
   logic [7:0] ISR;
   logic [7:0] CLR_IRR;
   logic [7:0] VECTOR;
   logic       VECTOR_VALID;

   modport slave (
      input  IRR, INTA, EOI_CMD, SPECIFIC_EOI, EOI_LEVEL, ROTATE_ON_EOI, AUTO_EOI, VECTOR_BASE,
      output INT, ISR, CLR_IRR, VECTOR, VECTOR_VALID
   );

   modport master (
      output IRR, INTA, EOI_CMD, SPECIFIC_EOI, EOI_LEVEL, ROTATE_ON_EOI, AUTO_EOI, VECTOR_BASE,
      input  INT, ISR, CLR_IRR, VECTOR, VECTOR_VALID
   );
endinterface

// File: rtl/pic_priority_isr.sv
// rtl/pic_priority_isr.sv - 8259 priority resolver, in-service register, INTA sequencer, EOI and rotation
module pic_priority_isr (
   input logic CLK,
   input logic RST,
   pic_priority_isr_if.slave bus
);
   typedef enum logic [0:0] {IDLE, ACK2} state_t;

   state_t     state, state_n;
   logic [2:0] lp, lp_n;
   logic [2:0] lvl, lvl_n;
   logic       spur, spur_n;
   logic [7:0] isr, isr_n;
   logic       int_q, int_n;
   logic [7:0] clr_q, clr_n;
   logic [7:0] vec_q, vec_n;
   logic       vv_q, vv_n;

   logic [2:0] win, top;
   logic       win_valid, top_valid;

   // Distance from the highest-priority slot; 0 is served first.
   function automatic logic [2:0] rank(input logic [2:0] lv, input logic [2:0] low);
      return lv - low - 3'd1;
   endfunction

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      win       = 3'd0;
      win_valid = 1'b0;
      top       = 3'd0;
      top_valid = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         logic [2:0] idx;
         idx = lp + 3'd1 + 3'(k);
         if (bus.IRR[idx]) begin
            win       = idx;
            win_valid = 1'b1;
         end
         if (isr[idx]) begin
            top       = idx;
            top_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      lp_n    = lp;
      lvl_n   = lvl;
      spur_n  = spur;
      isr_n   = isr;
      int_n   = 1'b0;
      clr_n   = 8'h00;
      vec_n   = vec_q;
      vv_n    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.INTA) begin
               state_n = ACK2;
               if (win_valid) begin
                  lvl_n  = win;
                  spur_n = 1'b0;
               end else begin
                  lvl_n  = 3'd7;
                  spur_n = 1'b1;
               end
            end
         end
         ACK2: begin
            if (bus.INTA) begin
               state_n = IDLE;
               vv_n    = 1'b1;
               vec_n   = {bus.VECTOR_BASE, lvl};
               if (bus.AUTO_EOI && !spur) begin
                  isr_n[lvl] = 1'b0;
                  if (bus.ROTATE_ON_EOI)
                     lp_n = lvl;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Explicit EOI comes after auto-EOI so its rotation level takes precedence.
      if (bus.EOI_CMD) begin
         if (bus.SPECIFIC_EOI) begin
            isr_n[bus.EOI_LEVEL] = 1'b0;
            if (bus.ROTATE_ON_EOI)
               lp_n = bus.EOI_LEVEL;
         end else if (top_valid) begin
            isr_n[top] = 1'b0;
            if (bus.ROTATE_ON_EOI)
               lp_n = top;
         end
      end

      // Setting the acknowledged bit last lets it win over a same-cycle clear.
      if (state == IDLE && bus.INTA && win_valid) begin
         isr_n[win] = 1'b1;
         clr_n[win] = 1'b1;
      end

      int_n = (state == IDLE) && !bus.INTA && win_valid &&
              (!top_valid || (rank(win, lp) < rank(top, lp)));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         lp    <= 3'd7;
         lvl   <= 3'd0;
         spur  <= 1'b0;
         isr   <= 8'h00;
         int_q <= 1'b0;
         clr_q <= 8'h00;
         vec_q <= 8'h00;
         vv_q  <= 1'b0;
      end else begin
         state <= state_n;
         lp    <= lp_n;
         lvl   <= lvl_n;
         spur  <= spur_n;
         isr   <= isr_n;
         int_q <= int_n;
         clr_q <= clr_n;
         vec_q <= vec_n;
         vv_q  <= vv_n;
      end
   end

   assign bus.INT          = int_q;
   assign bus.ISR          = isr;
   assign bus.CLR_IRR      = clr_q;
   assign bus.VECTOR       = vec_q;
   assign bus.VECTOR_VALID = vv_q;
endmodule

// File: tb/tb_pic_priority_isr.sv
// tb/tb_pic_priority_isr.sv - directed scoreboard bench for pic_priority_isr
module tb_pic_priority_isr;
   logic CLK = 1'b0;
   logic RST;
   pic_priority_isr_if bus();

   pic_priority_isr dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic push(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input logic [7:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic inta_step();
      bus.INTA = 1'b1;
      step();
      bus.INTA = 1'b0;
   endtask

   function automatic logic [7:0] b(input logic x);
      return {7'b0, x};
   endfunction

   initial begin
      RST = 1'b1;
      bus.IRR = 8'h00;
      bus.INTA = 1'b0;
      bus.EOI_CMD = 1'b0;
      bus.SPECIFIC_EOI = 1'b0;
      bus.EOI_LEVEL = 3'd0;
      bus.ROTATE_ON_EOI = 1'b0;
      bus.AUTO_EOI = 1'b0;
      bus.VECTOR_BASE = 5'b01000;
      step(); step();
      RST = 1'b0;

      // reset state
      push("rst_int", 8'h00); push("rst_isr", 8'h00); push("rst_clr", 8'h00);
      push("rst_vv", 8'h00); push("rst_vec", 8'h00);
      cmp(b(bus.INT)); cmp(bus.ISR); cmp(bus.CLR_IRR); cmp(b(bus.VECTOR_VALID)); cmp(bus.VECTOR);
      push("idle_int", 8'h00); step(); cmp(b(bus.INT));

      // first request and full acknowledge
      bus.IRR = 8'h28;
      push("int_rise", 8'h01); step(); cmp(b(bus.INT));
      push("ack1_isr", 8'h08); push("ack1_clr", 8'h08); push("ack1_int", 8'h00);
      inta_step(); cmp(bus.ISR); cmp(bus.CLR_IRR); cmp(b(bus.INT));
      bus.IRR = 8'h20;
      push("ack2_clr", 8'h00); push("ack2_int", 8'h00);
      step(); cmp(bus.CLR_IRR); cmp(b(bus.INT));
      push("vec_vv", 8'h01); push("vec_val", 8'h43);
      inta_step(); cmp(b(bus.VECTOR_VALID)); cmp(bus.VECTOR);
      push("vv_drop", 8'h00); push("vec_hold", 8'h43);
      step(); cmp(b(bus.VECTOR_VALID)); cmp(bus.VECTOR);

      // fully nested masking
      push("nest_low_int", 8'h00); step(); cmp(b(bus.INT));
      bus.IRR = 8'h22;
      push("nest_high_int", 8'h01); step(); cmp(b(bus.INT));
      bus.IRR = 8'h20;
      bus.EOI_CMD = 1'b1; bus.SPECIFIC_EOI = 1'b0;
      push("ns_eoi_isr", 8'h00); step(); cmp(bus.ISR);
      bus.EOI_CMD = 1'b0;
      push("post_eoi_int", 8'h01); step(); cmp(b(bus.INT));
      bus.IRR = 8'h00;
      step(); step();

      // auto-EOI with rotation
      bus.AUTO_EOI = 1'b1; bus.ROTATE_ON_EOI = 1'b1;
      bus.IRR = 8'h04;
      push("aeoi_int", 8'h01); step(); cmp(b(bus.INT));
      push("aeoi_isr_set", 8'h04); push("aeoi_clr", 8'h04);
      inta_step(); cmp(bus.ISR); cmp(bus.CLR_IRR);
      bus.IRR = 8'h00;
      step();
      push("aeoi_vec", 8'h42); push("aeoi_isr_clr", 8'h00);
      inta_step(); cmp(bus.VECTOR); cmp(bus.ISR);
      bus.IRR = 8'h09;
      push("rot_int", 8'h01); step(); cmp(b(bus.INT));
      push("rot_clr", 8'h08); inta_step(); cmp(bus.CLR_IRR);
      bus.IRR = 8'h01;
      step();
      push("rot_vec", 8'h43); push("rot_isr", 8'h00);
      inta_step(); cmp(bus.VECTOR); cmp(bus.ISR);
      bus.AUTO_EOI = 1'b0; bus.ROTATE_ON_EOI = 1'b0;
      bus.IRR = 8'h00;
      step();

      // spurious acknowledge
      push("spur_clr", 8'h00); push("spur_isr", 8'h00);
      inta_step(); cmp(bus.CLR_IRR); cmp(bus.ISR);
      step();
      push("spur_vv", 8'h01); push("spur_vec", 8'h47);
      inta_step(); cmp(b(bus.VECTOR_VALID)); cmp(bus.VECTOR);

      // reset in the middle of the acknowledge
      RST = 1'b1; step(); RST = 1'b0;
      bus.IRR = 8'h08;
      step();
      push("mid_isr", 8'h08); inta_step(); cmp(bus.ISR);
      bus.IRR = 8'h00;
      step();
      RST = 1'b1;
      push("mrst_vv", 8'h00); push("mrst_isr", 8'h00);
      step(); cmp(b(bus.VECTOR_VALID)); cmp(bus.ISR);
      RST = 1'b0;
      push("mrst_idle_vv", 8'h00); inta_step(); cmp(b(bus.VECTOR_VALID));
      push("mrst_end_vv", 8'h01); inta_step(); cmp(b(bus.VECTOR_VALID));

      // nested in-service then specific EOI
      bus.IRR = 8'h20;
      step();
      push("sp_isr5", 8'h20); inta_step(); cmp(bus.ISR);
      bus.IRR = 8'h00;
      step();
      inta_step();
      bus.IRR = 8'h08;
      push("sp_int3", 8'h01); step(); cmp(b(bus.INT));
      push("sp_isr28", 8'h28); inta_step(); cmp(bus.ISR);
      bus.IRR = 8'h00;
      step();
      inta_step();
      bus.EOI_CMD = 1'b1; bus.SPECIFIC_EOI = 1'b1; bus.EOI_LEVEL = 3'd5;
      push("sp_eoi_isr", 8'h08); step(); cmp(bus.ISR);
      bus.EOI_CMD = 1'b0; bus.SPECIFIC_EOI = 1'b0;
      step();

      if (exp_q.size() != 0) begin
         n_bad++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
